// File: rtl/req_pend_queue_pkg.sv
// req_pkg: shared sizes, vector/index types and one-hot helper for the request queue.
package req_pkg;
    localparam int N = 16;
    localparam int IDX_W = 4;
    typedef logic [N-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;
    function automatic req_vec_t onehot(input req_idx_t i);
        return req_vec_t'(1) << i;
    endfunction
endpackage

// File: rtl/req_pend_queue_if.sv
// req_pend_queue_if: request/mask inputs and indexed valid/ready output of the pending queue.
interface req_pend_queue_if;
    import req_pkg::*;
    req_vec_t req;
    req_vec_t mask;
    logic clr_all;
    logic ready;
    logic ovf_clr;
    req_idx_t idx;
    logic valid;
    req_vec_t pend;
    logic ovf;
    modport master (output req, mask, clr_all, ready, ovf_clr, input idx, valid, pend, ovf);
    modport slave (input req, mask, clr_all, ready, ovf_clr, output idx, valid, pend, ovf);
endinterface

// File: rtl/req_pend_queue_pri_enc.sv
// pri_enc16_4: combinational index of the most significant set bit, plus any-bit flag.
module pri_enc16_4
    import req_pkg::*;
(
    input  req_vec_t vec,
    output req_idx_t idx,
    output logic     any
);
    assign any = |vec;
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (vec[i]) idx = i[IDX_W-1:0];
    end
endmodule

// File: rtl/req_pend_queue.sv
// req_pend_queue: sticky pending bits for 16 request sources, presented highest-first
// through a registered valid/ready stage; an accepted index clears its pending bit.
module req_pend_queue
    import req_pkg::*;
(
    input logic clk,
    input logic rst_n,
    req_pend_queue_if.slave bus
);
    logic acc;
    req_vec_t clr_vec;
    req_vec_t pend_next;
    req_vec_t eligible;
    req_idx_t enc_idx;
    logic enc_any;
    logic ovf_set;

    assign acc = bus.valid & bus.ready;
    assign clr_vec = acc ? onehot(bus.idx) : '0;
    // A request on the bit being accepted re-arms it.
    assign pend_next = (bus.pend & ~clr_vec) | bus.req;
    assign eligible = pend_next & bus.mask;
    assign ovf_set = |(bus.req & bus.pend & ~clr_vec);

    pri_enc16_4 u_enc (.vec(eligible), .idx(enc_idx), .any(enc_any));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pend <= '0;
            bus.valid <= 1'b0;
            bus.idx <= '0;
            bus.ovf <= 1'b0;
        end else begin
            bus.ovf <= ovf_set | (bus.ovf & ~bus.ovf_clr);
            if (bus.clr_all) begin
                bus.pend <= '0;
                bus.valid <= 1'b0;
                bus.idx <= '0;
            end else begin
                bus.pend <= pend_next;
                // Held output is never preempted or retracted until accepted.
                if (!bus.valid || bus.ready) begin
                    bus.valid <= enc_any;
                    bus.idx <= enc_idx;
                end
            end
        end
    end
endmodule
